// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-step shift-add multiplier / restoring divider with HI/LO registers
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   start request, sampled only while busy=0
//   op    000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op
//   a, b  operands (dividend/multiplicand, divisor/multiplier)
//   hi    product upper half or remainder
//   lo    product lower half or quotient
//   busy  iterative operation in progress
//   done  one-cycle pulse after a multiply/divide result commits
//   Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise they act as MULTU/DIVU.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int W = WIDTH;
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, nxt;
    logic [5:0] cnt;
    logic [W-1:0] opr, abs_a, abs_b, rem_sh;
    logic [2*W-1:0] acc, mul_next, div_next, res;
    logic [W:0] msum, dsub;
    logic go_mul, go_div, last;
    assign go_mul = state == IDLE && start && op[2:1] == 2'b00;
    assign go_div = state == IDLE && start && op[2:1] == 2'b01;
    assign last = cnt == 6'(W - 1);
    // acc = {partial product, remaining multiplier}: add multiplicand on LSB, shift right
    assign msum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opr} : '0);
    assign mul_next = {msum, acc[W-1:1]};
    // acc = {remainder, dividend}: shift left, quotient bits enter from the right
    assign rem_sh = {acc[2*W-2:W], acc[W-1]};
    assign dsub = {acc[2*W-1:W], acc[W-1]} - {1'b0, opr};
    assign div_next = dsub[W] ? {rem_sh, acc[W-2:0], 1'b0} : {dsub[W-1:0], acc[W-2:0], 1'b1};
`ifdef MULDIV_SIGNED_EN
    logic sa, sb, is_div, neg_q, neg_r;
    assign sa = op[0] & a[W-1];
    assign sb = op[0] & b[W-1];
    assign abs_a = sa ? -a : a;
    assign abs_b = sb ? -b : b;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (go_mul || go_div) begin
            is_div <= go_div;
            neg_q <= sa ^ sb;
            neg_r <= sa;
        end
    end
    // multiply negates the full 64-bit product; divide fixes quotient and remainder separately
    assign res = is_div ? {neg_r ? -acc[2*W-1:W] : acc[2*W-1:W], neg_q ? -acc[W-1:0] : acc[W-1:0]}
                        : (neg_q ? -acc : acc);
`else
    assign abs_a = a;
    assign abs_b = b;
    assign res = acc;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = go_mul ? MUL : go_div ? DIV : IDLE;
            MUL, DIV: nxt = last ? FIX : state;
            FIX:      nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end
    always_comb busy = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
            done <= 1'b0;
            cnt <= '0;
            opr <= '0;
            acc <= '0;
        end else begin
            done <= state == FIX;
            if (go_mul || go_div) begin
                cnt <= '0;
                opr <= go_mul ? abs_a : abs_b;
                acc <= {{W{1'b0}}, go_mul ? abs_b : abs_a};
            end
            if (state == MUL || state == DIV) begin
                cnt <= cnt + 6'd1;
                acc <= state == MUL ? mul_next : div_next;
            end
            if (state == IDLE && start && op == 3'b100) hi <= a;
            if (state == IDLE && start && op == 3'b101) lo <= a;
            if (state == FIX) {hi, lo} <= res;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0] op = '0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] hi, lo;
    logic busy, done;
    int vectors = 0, miscompares = 0;
    bit armed = 1'b0;
    logic [31:0] m_hi, m_lo;
    logic m_done;
    int m_left;
    logic [63:0] m_pend;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic sg;
        longint sx, sy, q, r;
        sg = SIGNED_EN && o[0];
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o[1]) return sg ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
        if (y == 0) return {x, (sg && x[31]) ? 32'h1 : 32'hFFFF_FFFF};
        if (sg) begin
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
        end
        return {x % y, x / y};
    endfunction

    function automatic logic [31:0] pick();
        int k;
        k = $urandom_range(0, 7);
        return k == 0 ? 32'h0 : k == 1 ? 32'hFFFF_FFFF : k == 2 ? 32'h8000_0000 :
               k == 3 ? 32'($urandom_range(0, 20)) : k == 4 ? 32'h7FFF_FFFF : 32'($urandom);
    endfunction

    // result lands 33 edges after acceptance; starts are ignored while an op is pending
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi <= '0;
            m_lo <= '0;
            m_done <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi <= m_pend[63:32];
                    m_lo <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (op < 3'd4) begin
                    m_pend <= ref_res(op, a, b);
                    m_left <= 33;
                end else if (op == 3'd4) m_hi <= a;
                else if (op == 3'd5) m_lo <= a;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            vectors++;
            if ({hi, lo, busy, done} !== {m_hi, m_lo, m_left > 0, m_done}) begin
                miscompares++;
                $display("FAIL cycle model @%0t: hi=%h lo=%h busy=%b done=%b, required hi=%h lo=%h busy=%b done=%b",
                         $time, hi, lo, busy, done, m_hi, m_lo, m_left > 0, m_done);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #2;
        start = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
        issue(o, x, y);
        repeat (32) @(posedge clk);
        @(negedge clk);
        chk({nm, " busy before commit"}, {busy, done}, 2'b10);
        @(negedge clk);
        chk({nm, " result"}, {hi, lo}, {eh, el});
        chk({nm, " flags at commit"}, {busy, done}, 2'b01);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        armed = 1'b1;
        @(negedge clk);
        chk("reset hi/lo", {hi, lo}, 64'h0);
        chk("reset flags", {busy, done}, 2'b00);
        rst = 1'b0;
        run_op("multu max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        chk("done single cycle", done, 1'b0);
        run_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd7, SIGNED_EN ? 32'hFFFF_FFFF : 32'h6, 32'hFFFF_FFEB);
        run_op("div neg", 3'd3, 32'hFFFF_FFF9, 32'd2, SIGNED_EN ? 32'hFFFF_FFFF : 32'h1,
               SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC);
        run_op("divu by zero", 3'd2, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF);
        run_op("div overflow", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, SIGNED_EN ? 32'h0 : 32'h8000_0000,
               SIGNED_EN ? 32'h8000_0000 : 32'h0);
        run_op("div neg by zero", 3'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SIGNED_EN ? 32'h1 : 32'hFFFF_FFFF);
        @(negedge clk);
        issue(3'd4, 32'h1234_5678, 32'h0);
        @(negedge clk);
        chk("mthi hi", hi, 32'h1234_5678);
        chk("mthi flags", {busy, done}, 2'b00);
        issue(3'd5, 32'hCAFE_F00D, 32'h0);
        @(negedge clk);
        chk("mtlo lo", lo, 32'hCAFE_F00D);
        issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd7, 32'h0, 32'h0);
        @(negedge clk);
        chk("no-op state", {hi, lo}, {32'h1234_5678, 32'hCAFE_F00D});
        chk("no-op flags", {busy, done}, 2'b00);
        issue(3'd2, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #2;
        issue(3'd4, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        chk("mthi while busy", hi, 32'h1234_5678);
        repeat (27) @(negedge clk);
        chk("divu after ignored mthi", {hi, lo}, {32'd6, 32'd142});
        chk("divu done", done, 1'b1);
        issue(3'd0, 32'h00AB_CDEF, 32'h0000_1234);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk("abort hi/lo", {hi, lo}, 64'h0);
        chk("abort flags", {busy, done}, 2'b00);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op("multu after rst", 3'd0, 32'd3, 32'd5, 32'd0, 32'd15);
        run_op("b2b first", 3'd0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);
        run_op("b2b divu", 3'd2, 32'd9, 32'd4, 32'd1, 32'd2);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            start = $urandom_range(0, 2) == 0;
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            rst = $urandom_range(0, 999) == 0;
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; all values below assume 32.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled on a rising edge only while busy=0.
REQ-005 op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 a  input  32  operand A (register-file port A: rs value; dividend or multiplicand).
REQ-007 b  input  32  operand B (register-file port B: rt value; divisor or multiplier).
REQ-008 hi  output  32  HI register (product upper half or remainder).
REQ-009 lo  output  32  LO register (product lower half or quotient).
REQ-010 busy  output  1  iterative operation in progress.
REQ-011 done  output  1  one-cycle pulse after a multiply or divide result commits.

Function
REQ-012 The block SHALL implement a 4-state FSM: IDLE, MUL, DIV, FIX.
REQ-013 IDLE: start=1 with op MULT/MULTU SHALL latch operands, load a 6-bit iteration counter to 0, go to MUL, and set busy=1 on that edge.
REQ-014 IDLE: start=1 with op DIV/DIVU SHALL do the same, going to DIV.
REQ-015 MUL SHALL perform one shift-add step per cycle on |a|, |b| (signed) or a, b (unsigned); after 32 steps go to FIX.
REQ-016 DIV SHALL perform one restoring shift-subtract step per cycle, producing 1 quotient bit per cycle; after 32 steps go to FIX.
REQ-017 FIX SHALL apply sign correction and write hi/lo, clear busy, set done=1 for exactly one cycle, and return to IDLE.
REQ-018 Latency: with the start edge as edge 0, hi/lo update and busy clears at edge 33; done is high between edges 33 and 34.
REQ-019 hi/lo SHALL hold their previous values until the commit edge; no intermediate values are visible.
REQ-020 Signed multiply: a negated 64-bit product SHALL be used when sign(a) XOR sign(b).
REQ-021 Signed divide: the quotient is negated when sign(a) XOR sign(b); the remainder takes the sign of a.
REQ-022 Divide by zero is not trapped and SHALL give the natural restoring result.
REQ-023 DIVU x/0 SHALL give lo=0xFFFFFFFF, hi=x.
REQ-024 DIV x/0 SHALL give hi=x, with lo=0xFFFFFFFF for x>=0 and lo=0x00000001 for x<0.
REQ-025 DIV 0x80000000/0xFFFFFFFF SHALL give lo=0x80000000, hi=0 (no trap).
REQ-026 MTHI/MTLO with start=1 in IDLE SHALL write a to hi or lo on that edge; busy and done stay 0, and the FSM stays IDLE.
REQ-027 Op 110/111 with start=1 SHALL change no state.
REQ-028 start while busy=1 SHALL be ignored, including MTHI/MTLO; operands may change freely during busy.
REQ-029 A start in the same cycle as done=1 (busy already 0) SHALL be accepted normally.

Reset
REQ-030 rst=1 SHALL immediately clear hi, lo, busy, done, the counter, and the operand/partial registers, and force IDLE.
REQ-031 rst asserted mid-operation SHALL abort it without a done pulse.
REQ-032 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-033 Macro MULDIV_SIGNED_EN defined: MULT/DIV SHALL be signed per REQ-020/021/024/025, with absolute-value and sign-fix logic present.
REQ-034 Macro undefined: op 001 SHALL behave as MULTU and 011 as DIVU; sign logic is omitted, while FIX and 33-edge latency are retained.

Verification
REQ-035 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at edge 33, done pulse 1 cycle.
REQ-036 MULT a=0xFFFFFFFD b=7 -> with macro hi=0xFFFFFFFF, lo=0xFFFFFFEB; without macro hi=0x00000006, lo=0xFFFFFFEB.
REQ-037 DIV a=0xFFFFFFF9 b=2 (macro) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-038 MTHI a=0x12345678 -> hi=0x12345678 next edge, busy=0, done=0; then MTHI issued during a DIVU -> hi unchanged until DIVU commit.
REQ-039 Start MULTU, assert rst at edge 10 -> hi=lo=0, busy=0, no done; a new MULTU 3x5 then gives lo=15, hi=0 at edge 33.
REQ-040 Back-to-back: a new start DIVU 9/4 in the done cycle -> lo=2, hi=1 exactly 33 edges later.
